sort_stream_arbiter: RTL and testbench
======================================

// Module: sort_stream_arbiter
// PURPOSE
//  Shares one insertion_sort engine between NUM_SRC AXI-stream producers on a whole-packet basis.
//  A round-robin scheduler grants one source, feeds its packet into the sorter, then drains the sorted packet to a single output tagged with the source id.
//  Sits between the per-channel ingest streams and the insertion_sort instance; the output goes to the result router.
// PARAMETERS
//  NUM_SRC     4  number of requesting streams (2..16)
//  DATA_WIDTH  8  element width; must match the sorter
//  ID_WIDTH    2  width of source id; must equal clog2(NUM_SRC)
// PORTS
//  clk               in   1                    clock
//  rst               in   1                    synchronous, active-high reset
//  s_tvalid          in   NUM_SRC              per-source valid
//  s_tready          out  NUM_SRC              per-source ready
//  s_tdata           in   NUM_SRC*DATA_WIDTH   source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tlast           in   NUM_SRC              per-source end of packet
//  srt_in_tvalid     out  1                    to sorter src_tvalid
//  srt_in_tready     in   1                    from sorter src_tready
//  srt_in_tdata      out  DATA_WIDTH           to sorter src_tdata
//  srt_in_tlast      out  1                    to sorter src_tlast
//  srt_tlast_err     in   1                    sorter full: packet force-terminated
//  srt_out_tvalid    in   1                    from sorter dest_tvalid
//  srt_out_tready    out  1                    to sorter dest_tready
//  srt_out_tdata     in   DATA_WIDTH           from sorter dest_tdata
//  srt_out_tlast     in   1                    from sorter dest_tlast
//  m_tvalid          out  1                    sorted output valid
//  m_tready          in   1                    downstream ready
//  m_tdata           out  DATA_WIDTH           sorted element
//  m_tlast           out  1                    last element of sorted packet (or segment)
//  m_tid             out  ID_WIDTH             source id of current output packet
//  overflow          out  1                    one-cycle pulse when a packet is split by sorter overflow
//  busy              out  1                    high whenever state != IDLE
// BEHAVIOUR
//  States: IDLE, FEED, DRAIN. Registers: state, grant (ID_WIDTH), last_grant (ID_WIDTH), cont (1).
//  Reset: state=IDLE, last_grant=NUM_SRC-1 (source 0 has top priority), cont=0, overflow=0.
//   All of s_tready, srt_in_tvalid, srt_out_tready, m_tvalid and busy are 0 during and after reset.
//   Reset mid-packet abandons the packet; the sorter shares rst, so no data survives.
//  IDLE: if any s_tvalid is set, grant = first set index scanning last_grant+1, +2, ... with wrap modulo NUM_SRC.
//   Registered; go to FEED the next cycle. Nothing is consumed in IDLE. No request: remain in IDLE.
//  FEED: srt_in_* = s_*[grant] combinationally; s_tready[grant] = srt_in_tready; all other s_tready = 0.
//   srt_out_tready=0. Handshake = s_tvalid[grant] && srt_in_tready.
//   Handshake with s_tlast[grant] -> DRAIN, cont=0, last_grant=grant.
//   Handshake with srt_tlast_err and !s_tlast[grant] -> DRAIN, cont=1, overflow pulses for 1 cycle.
//  DRAIN: m_tvalid=srt_out_tvalid, m_tdata=srt_out_tdata, m_tlast=srt_out_tlast.
//   srt_out_tready=m_tready; m_tid=grant (stable for the whole packet). All s_tready = 0.
//   Handshake with srt_out_tlast: if cont then FEED (same grant, no re-arbitration), else IDLE.
//  Latency: grant-to-first-accept is 1 cycle after the IDLE decision (request seen at cycle n, first accept possible at n+1).
//   Sort results follow the sorter's eject timing; m adds no register stage (pure pass-through mux).
//  Continuation segments are emitted as separate m_tlast-terminated packets with the same m_tid.
//  The block never drops or duplicates beats. A source whose s_tvalid falls mid-packet simply stalls FEED.
//  NUM_SRC not a power of two: the round-robin scan only visits indices 0..NUM_SRC-1.
// TESTING
//  Src0 sends {5,3,9} with tlast, others idle -> m emits 3,5,9, m_tid=0, tlast on 9, then IDLE.
//  Src1 and src3 request together after reset -> src1 served first, then src3; a later src1 request is served after src3.
//  All 4 sources request continuously, 2-beat packets -> grant order 0,1,2,3,0,...; no source starved.
//  Sorter depth 4, src2 sends 6 beats {6,1,5,2,4,3} -> overflow pulse; m gets 1,2,5,6 (tid 2), then 3,4 (tid 2).
//  m_tready toggles 1/0 during DRAIN -> no beat lost or repeated; m_tdata and m_tid held while stalled.
//  rst asserted mid-FEED of src0 -> all readies and valids 0 next cycle; after release, src1 requesting -> src1 granted.

Source files
------------

// File: rtl/sort_stream_arbiter.sv
// Round-robin whole-packet arbiter that shares one insertion sorter
// between several streams and drains the sorted packet tagged with its source.
module sort_stream_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic                          srt_in_tvalid,
  input  logic                          srt_in_tready,
  output logic [DATA_WIDTH-1:0]         srt_in_tdata,
  output logic                          srt_in_tlast,
  input  logic                          srt_tlast_err,
  input  logic                          srt_out_tvalid,
  output logic                          srt_out_tready,
  input  logic [DATA_WIDTH-1:0]         srt_out_tdata,
  input  logic                          srt_out_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tlast,
  output logic [ID_WIDTH-1:0]           m_tid,
  output logic                          overflow,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                cont_q, cont_d;
  logic                ovf_q, ovf_d;

  logic [ID_WIDTH-1:0]   pick;
  logic                  found;
  int unsigned           idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan starts just past the previous winner so every source gets a turn
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (!found && s_tvalid[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

  assign sel_valid = s_tvalid[grant_q];
  assign sel_last  = s_tlast[grant_q];
  assign sel_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_SRC - 1);
      cont_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cont_q       <= cont_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cont_d         = cont_q;
    ovf_d          = 1'b0;
    s_tready       = '0;
    srt_in_tvalid  = 1'b0;
    srt_in_tdata   = '0;
    srt_in_tlast   = 1'b0;
    srt_out_tready = 1'b0;
    m_tvalid       = 1'b0;
    m_tdata        = '0;
    m_tlast        = 1'b0;
    m_tid          = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = FEED;
        end
      end
      FEED: begin
        srt_in_tvalid     = sel_valid;
        srt_in_tdata      = sel_data;
        srt_in_tlast      = sel_last;
        s_tready[grant_q] = srt_in_tready;
        if (sel_valid && srt_in_tready) begin
          if (sel_last) begin
            state_d      = DRAIN;
            cont_d       = 1'b0;
            last_grant_d = grant_q;
          end else if (srt_tlast_err) begin
            state_d = DRAIN;
            cont_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        m_tvalid       = srt_out_tvalid;
        m_tdata        = srt_out_tdata;
        m_tlast        = srt_out_tlast;
        srt_out_tready = m_tready;
        if (srt_out_tvalid && m_tready && srt_out_tlast) begin
          state_d = cont_q ? FEED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs stay quiet for as long as reset is held
    if (rst) begin
      s_tready       = '0;
      srt_in_tvalid  = 1'b0;
      srt_out_tready = 1'b0;
      m_tvalid       = 1'b0;
    end
  end

  assign overflow = ovf_q && !rst;
  assign busy     = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_sort_stream_arbiter.sv
// Bench for sort_stream_arbiter: source BFMs, a depth-4 sorter model,
// and a per-source segment scoreboard plus directed literal checks.
module tb_sort_stream_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tready;
  logic [NS*DW-1:0] s_tdata = '0;
  logic [NS-1:0]   s_tlast = '0;
  logic            srt_in_tvalid;
  logic            srt_in_tready;
  logic [DW-1:0]   srt_in_tdata;
  logic            srt_in_tlast;
  logic            srt_tlast_err;
  logic            srt_out_tvalid;
  logic            srt_out_tready;
  logic [DW-1:0]   srt_out_tdata = '0;
  logic            srt_out_tlast = 1'b0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [1:0]      m_tid;
  logic            overflow;
  logic            busy;

  sort_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast),
    .srt_in_tvalid(srt_in_tvalid), .srt_in_tready(srt_in_tready),
    .srt_in_tdata(srt_in_tdata), .srt_in_tlast(srt_in_tlast),
    .srt_tlast_err(srt_tlast_err),
    .srt_out_tvalid(srt_out_tvalid), .srt_out_tready(srt_out_tready),
    .srt_out_tdata(srt_out_tdata), .srt_out_tlast(srt_out_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tid(m_tid),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
  } beat_t;

  beat_t srcq[NS][$];
  beat_t exp_q[NS][$];
  int    out_log[$];
  int    tid_log[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    ovf_cnt = 0;
  int    exp_ovf = 0;
  bit    starting = 1'b1;
  bit    toggle = 1'b0;

  // sorter model state
  int sm_q[$];
  int sm_mode = 0;
  int sm_cnt = 0;
  int sm_rd = 0;

  assign srt_in_tready  = !rst && sm_mode == 0;
  assign srt_tlast_err  = sm_mode == 0 && sm_cnt == DEPTH - 1;
  assign srt_out_tvalid = !rst && sm_mode == 1;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic chk_list(input string name, input int got[$], input int want[$]);
    chk({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
  endtask

  // Expected output: each packet split into sorter-sized chunks, each sorted
  task automatic add_pkt(input int s, input int v[$]);
    int c[$];
    beat_t b;
    for (int i = 0; i < v.size(); i++) begin
      b.d = DW'(v[i]);
      b.l = (i == v.size() - 1);
      srcq[s].push_back(b);
    end
    for (int base = 0; base < v.size(); base += DEPTH) begin
      c = {};
      for (int i = base; i < base + DEPTH && i < v.size(); i++)
        c.push_back(v[i]);
      c.sort();
      for (int i = 0; i < c.size(); i++) begin
        b.d = DW'(c[i]);
        b.l = (i == c.size() - 1);
        exp_q[s].push_back(b);
      end
      if (base > 0) exp_ovf++;
    end
  endtask

  // source BFMs
  initial begin
    logic [NS-1:0] hs;
    forever begin
      @(posedge clk);
      hs = s_tvalid & s_tready;
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = srcq[i][0].d;
          s_tlast[i] = srcq[i][0].l;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i] = 1'b0;
        end
      end
    end
  end

  // sorter model: fills up to DEPTH, then ejects ascending
  initial begin
    bit in_hs, in_l, out_hs;
    int in_d, pos;
    forever begin
      @(posedge clk);
      in_hs  = srt_in_tvalid && srt_in_tready;
      in_d   = int'(srt_in_tdata);
      in_l   = srt_in_tlast;
      out_hs = srt_out_tvalid && srt_out_tready;
      #1;
      if (rst) begin
        sm_q = {};
        sm_mode = 0;
        sm_rd = 0;
      end else begin
        if (in_hs) begin
          pos = sm_q.size();
          for (int i = sm_q.size() - 1; i >= 0; i--)
            if (sm_q[i] > in_d) pos = i;
          sm_q.insert(pos, in_d);
          if (in_l || sm_q.size() == DEPTH) sm_mode = 1;
        end
        if (out_hs) begin
          sm_rd++;
          if (sm_rd >= sm_q.size()) begin
            sm_q = {};
            sm_rd = 0;
            sm_mode = 0;
          end
        end
      end
      sm_cnt = sm_q.size();
      srt_out_tdata = (sm_rd < sm_q.size()) ? DW'(sm_q[sm_rd]) : '0;
      srt_out_tlast = (sm_q.size() > 0) && (sm_rd == sm_q.size() - 1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = toggle ? !m_tready : 1'b1;
    end
  end

  // compare process
  initial begin
    bit held_v = 1'b0;
    int held_d = 0;
    int held_id = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          vectors++;
          if (!(m_tvalid && int'(m_tdata) == held_d && int'(m_tid) == held_id)) begin
            miscompares++;
            $display("FAIL stall_hold: v=%0d d=%0d id=%0d, expected d=%0d id=%0d",
                     m_tvalid, m_tdata, m_tid, held_d, held_id);
          end
        end
        held_v  = m_tvalid && !m_tready;
        held_d  = int'(m_tdata);
        held_id = int'(m_tid);
        chk("s_tready_onehot", int'($countones(s_tready) <= 1), 1);
        if (overflow) ovf_cnt++;
        if (m_tvalid && m_tready) begin
          out_log.push_back(int'(m_tdata));
          if (starting) tid_log.push_back(int'(m_tid));
          starting = m_tlast;
          vectors++;
          if (exp_q[m_tid].size() == 0) begin
            miscompares++;
            $display("FAIL extra_beat: tid=%0d data=%0d, expected none", m_tid, m_tdata);
          end else begin
            e = exp_q[m_tid].pop_front();
            if (m_tdata != e.d || m_tlast != e.l) begin
              miscompares++;
              $display("FAIL beat tid%0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                       m_tid, m_tdata, m_tlast, e.d, e.l);
            end
          end
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      srcq[i] = {};
      exp_q[i] = {};
    end
    out_log = {};
    tid_log = {};
    starting = 1'b1;
    ovf_cnt = 0;
    exp_ovf = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    toggle = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'({s_tready, srt_in_tvalid, srt_out_tready, m_tvalid}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_ready", int'({s_tready, srt_in_tvalid, srt_out_tready, m_tvalid}), 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    bit pend = 1'b1;
    while (pend && n < 2000) begin
      @(negedge clk);
      n++;
      pend = 1'b0;
      for (int i = 0; i < NS; i++)
        if (srcq[i].size() > 0 || exp_q[i].size() > 0) pend = 1'b1;
    end
    chk({name, "_done"}, int'(pend), 0);
    @(negedge clk);
    chk({name, "_idle"}, int'(busy), 0);
    chk({name, "_ovf"}, ovf_cnt, exp_ovf);
  endtask

  initial begin
    int pk[$];
    int want[$];

    // single source, request-to-accept latency
    do_reset();
    @(posedge clk);
    pk = '{5, 3, 9};
    add_pkt(0, pk);
    @(negedge clk);
    chk("t1_decide_busy", int'(busy), 0);
    chk("t1_decide_ready", int'(s_tready), 0);
    @(negedge clk);
    chk("t1_feed_ready", int'(s_tready), 1);
    wait_done("t1");
    want = '{3, 5, 9};
    chk_list("t1_data", out_log, want);
    want = '{0};
    chk_list("t1_tid", tid_log, want);

    // src1 and src3 together, src1 again afterwards
    do_reset();
    @(posedge clk);
    pk = '{2, 1};
    add_pkt(1, pk);
    pk = '{8, 7};
    add_pkt(3, pk);
    pk = '{6, 4};
    add_pkt(1, pk);
    wait_done("t2");
    want = '{1, 3, 1};
    chk_list("t2_tid", tid_log, want);
    want = '{1, 2, 7, 8, 4, 6};
    chk_list("t2_data", out_log, want);

    // all four sources, two packets each
    do_reset();
    @(posedge clk);
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) begin
        pk = '{s * 10 + r * 2 + 1, s * 10 + r * 2};
        add_pkt(s, pk);
      end
    wait_done("t3");
    want = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_list("t3_tid", tid_log, want);

    // sorter overflow splits the packet
    do_reset();
    @(posedge clk);
    pk = '{6, 1, 5, 2, 4, 3};
    add_pkt(2, pk);
    wait_done("t4");
    want = '{1, 2, 5, 6, 3, 4};
    chk_list("t4_data", out_log, want);
    want = '{2, 2};
    chk_list("t4_tid", tid_log, want);
    chk("t4_ovf_lit", ovf_cnt, 1);

    // downstream back-pressure
    do_reset();
    toggle = 1'b1;
    @(posedge clk);
    pk = '{7, 2, 8, 1};
    add_pkt(0, pk);
    wait_done("t5");
    want = '{1, 2, 7, 8};
    chk_list("t5_data", out_log, want);
    toggle = 1'b0;

    // reset in the middle of feeding src0
    do_reset();
    @(posedge clk);
    pk = '{4, 9, 2};
    add_pkt(0, pk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_feeding", int'(s_tready), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    chk("t6_rst_ready", int'({s_tready, srt_in_tvalid, srt_out_tready, m_tvalid, busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pk = '{2, 1};
    add_pkt(1, pk);
    wait_done("t6");
    want = '{1};
    chk_list("t6_tid", tid_log, want);
    want = '{1, 2};
    chk_list("t6_data", out_log, want);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
